// File: rtl/id_alu_issue.sv
// id_alu_issue: registered RV32I decode/issue stage producing ALU operands, opcode and writeback control.
module id_alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rdi;
  logic [31:0] imm_i, imm_s, imm_u, d_a, d_b;
  logic [3:0] f3_op, d_op;
  logic d_ok, d_wb, accept;
  assign opc = instr[6:0];
  assign rdi = instr[11:7];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready && !flush;
  always_comb begin
    case (f3)
      3'b000:  f3_op = ADD;
      3'b001:  f3_op = SLL;
      3'b010:  f3_op = SLT;
      3'b011:  f3_op = SLTU;
      3'b100:  f3_op = XOR;
      3'b101:  f3_op = SRL;
      3'b110:  f3_op = OR;
      default: f3_op = AND;
    endcase
  end
  always_comb begin
    d_a = '0;
    d_b = '0;
    d_op = ADD;
    d_ok = 1'b1;
    d_wb = 1'b0;
    case (opc)
      7'b0110011: begin
        d_a = rs1_data;
        d_b = rs2_data;
        d_wb = 1'b1;
        d_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        d_op = f7[5] ? (f3 == 3'b000 ? SUB : SRA) : f3_op;
      end
      7'b0010011: begin
        d_a = rs1_data;
        d_wb = 1'b1;
        d_b = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr[24:20]} : imm_i;
        d_ok = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        d_op = (f3 == 3'b101 && f7[5]) ? SRA : f3_op;
      end
      7'b0110111: begin
        d_b = imm_u;
        d_wb = 1'b1;
      end
      7'b0010111: begin
        d_a = pc;
        d_b = imm_u;
        d_wb = 1'b1;
      end
      7'b0000011: begin
        d_a = rs1_data;
        d_b = imm_i;
        d_wb = 1'b1;
      end
      7'b0100011: begin
        d_a = rs1_data;
        d_b = imm_s;
      end
      default: d_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      alu_op <= ADD;
      rd <= '0;
      reg_write <= 1'b0;
      illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (accept) begin
        op_a <= d_ok ? d_a : '0;
        op_b <= d_ok ? d_b : '0;
        alu_op <= d_ok ? d_op : ADD;
        rd <= (d_ok && d_wb) ? rdi : '0;
        reg_write <= d_ok && d_wb && rdi != 5'd0;
        illegal <= !d_ok;
        if (!d_ok && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_id_alu_issue.sv
// tb_id_alu_issue: directed and randomized checks of id_alu_issue against a rule-level model.
module tb_id_alu_issue;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, op_a, op_b;
  logic [3:0] alu_op;
  logic [4:0] rd;
  logic reg_write, illegal;
  logic [15:0] illegal_cnt;
  logic out_valid2, in_ready2, reg_write2, illegal2;
  logic [31:0] op_a2, op_b2;
  logic [3:0] alu_op2;
  logic [4:0] rd2;
  logic [1:0] illegal_cnt2;
  int n = 0, errs = 0;

  typedef struct packed {
    logic ill;
    logic [31:0] a, b;
    logic [3:0] op;
    logic [4:0] rd;
    logic we;
  } dec_t;

  localparam logic [3:0] F3OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  localparam logic [6:0] OPC [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};

  dec_t m_d = '0;
  logic m_valid = 1'b0;
  int m_cnt = 0, m_cnt2 = 0;

  id_alu_issue dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .rd(rd), .reg_write(reg_write),
    .illegal(illegal), .illegal_cnt(illegal_cnt));

  id_alu_issue #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .op_a(op_a2), .op_b(op_b2), .alu_op(alu_op2),
    .rd(rd2), .reg_write(reg_write2), .illegal(illegal2), .illegal_cnt(illegal_cnt2));

  always #5 clk = ~clk;

  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pcv, input logic [31:0] r1,
                                   input logic [31:0] r2);
    dec_t d = '0;
    logic ok = 1'b1, wr = 1'b1;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [31:0] si = 32'($signed(i[31:20]));
    logic [11:0] s12 = {i[31:25], i[11:7]};
    case (i[6:0])
      7'h33: begin
        d.a = r1; d.b = r2;
        if (f7 == 0) d.op = F3OP[f3];
        else if (f7 == 7'h20 && f3 == 0) d.op = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) d.op = 4'd7;
        else ok = 0;
      end
      7'h13: begin
        d.a = r1;
        if (f3 == 1) begin d.b = 32'(i[24:20]); d.op = 4'd5; ok = (f7 == 0); end
        else if (f3 == 5) begin d.b = 32'(i[24:20]); d.op = (f7 == 7'h20) ? 4'd7 : 4'd6; ok = (f7 == 0 || f7 == 7'h20); end
        else begin d.b = si; d.op = F3OP[f3]; end
      end
      7'h37: d.b = i & 32'hFFFFF000;
      7'h17: begin d.a = pcv; d.b = i & 32'hFFFFF000; end
      7'h03: begin d.a = r1; d.b = si; end
      7'h23: begin d.a = r1; d.b = 32'($signed(s12)); wr = 0; end
      default: ok = 0;
    endcase
    if (!ok) begin d = '0; d.ill = 1'b1; end
    else begin d.rd = wr ? i[11:7] : 5'd0; d.we = wr && i[11:7] != 0; end
    return d;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 7);
    if (k < 6) w[6:0] = OPC[k];
    if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic tick();
    dec_t d = ref_dec(instr, pc, rs1_data, rs2_data);
    logic acc = in_valid && (!m_valid || out_ready) && !flush;
    @(posedge clk);
    #1;
    if (acc) begin
      m_d = d;
      if (d.ill) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
  endtask

  task automatic test_reset();
    #12;
    n++; if (out_valid !== 0) begin errs++; $display("FAIL reset out_valid got %0b want 0", out_valid); end
    n++; if ({op_a, op_b, alu_op, rd} !== '0) begin errs++; $display("FAIL reset data got %h %h %0d %0d want zeros", op_a, op_b, alu_op, rd); end
    n++; if ({reg_write, illegal, illegal_cnt} !== '0) begin errs++; $display("FAIL reset ctl got %0b %0b %0d want 0", reg_write, illegal, illegal_cnt); end
    n++; if (in_ready !== 1) begin errs++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    in_valid = 1; out_ready = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 3;
    tick();
    n++; if ({out_valid, op_a, op_b, alu_op, rd, reg_write} !== {1'b1, 32'd5, 32'd3, 4'd0, 5'd3, 1'b1}) begin
      errs++; $display("FAIL add got v=%0b a=%0d b=%0d op=%0d rd=%0d we=%0b want 1 5 3 0 3 1", out_valid, op_a, op_b, alu_op, rd, reg_write); end
    instr = 32'h402081B3;
    tick();
    n++; if (alu_op !== 4'd1) begin errs++; $display("FAIL sub alu_op got %0d want 1", alu_op); end
  endtask

  task automatic test_srai_lui();
    instr = 32'h40335293; rs1_data = 32'h80000000;
    tick();
    n++; if ({op_a, op_b, alu_op, rd, illegal} !== {32'h80000000, 32'd3, 4'd7, 5'd5, 1'b0}) begin
      errs++; $display("FAIL srai got a=%h b=%h op=%0d rd=%0d ill=%0b want 80000000 3 7 5 0", op_a, op_b, alu_op, rd, illegal); end
    instr = 32'h123450B7;
    tick();
    n++; if ({op_a, op_b, alu_op, rd, reg_write} !== {32'd0, 32'h12345000, 4'd0, 5'd1, 1'b1}) begin
      errs++; $display("FAIL lui got a=%h b=%h op=%0d rd=%0d we=%0b want 0 12345000 0 1 1", op_a, op_b, alu_op, rd, reg_write); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; instr = 32'h002081B3; rs1_data = 7; rs2_data = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n++; if (in_ready !== 0) begin errs++; $display("FAIL stall in_ready got %0b want 0", in_ready); end
      tick();
      n++; if ({out_valid, op_b, rd} !== {1'b1, 32'h12345000, 5'd1}) begin
        errs++; $display("FAIL stall hold got v=%0b b=%h rd=%0d want 1 12345000 1", out_valid, op_b, rd); end
    end
    out_ready = 1;
    #1;
    n++; if (in_ready !== 1) begin errs++; $display("FAIL release in_ready got %0b want 1", in_ready); end
    tick();
    n++; if ({out_valid, op_a, op_b, rd} !== {1'b1, 32'd7, 32'd9, 5'd3}) begin
      errs++; $display("FAIL release got v=%0b a=%0d b=%0d rd=%0d want 1 7 9 3", out_valid, op_a, op_b, rd); end
  endtask

  task automatic test_flush();
    flush = 1; instr = 32'h0;
    tick();
    n++; if (out_valid !== 0) begin errs++; $display("FAIL flush out_valid got %0b want 0", out_valid); end
    flush = 0; in_valid = 0;
    tick();
    n++; if ({out_valid, illegal_cnt} !== {1'b0, 16'd0}) begin
      errs++; $display("FAIL flush drop got v=%0b cnt=%0d want 0 0", out_valid, illegal_cnt); end
  endtask

  task automatic test_illegal();
    in_valid = 1; instr = 32'h0;
    tick();
    n++; if ({out_valid, illegal, reg_write, op_a, op_b, rd, illegal_cnt} !== {3'b110, 64'd0, 5'd0, 16'd1}) begin
      errs++; $display("FAIL illegal got v=%0b ill=%0b we=%0b a=%h b=%h rd=%0d cnt=%0d want 1 1 0 0 0 0 1", out_valid, illegal, reg_write, op_a, op_b, rd, illegal_cnt); end
    for (int i = 0; i < 4; i++) tick();
    n++; if (illegal_cnt !== 16'd5) begin errs++; $display("FAIL cnt16 got %0d want 5", illegal_cnt); end
    n++; if (illegal_cnt2 !== 2'd3) begin errs++; $display("FAIL cnt2 saturate got %0d want 3", illegal_cnt2); end
  endtask

  task automatic test_reset_mid();
    #2; rst_n = 0; #1;
    n++; if ({out_valid, illegal_cnt, illegal_cnt2} !== '0) begin
      errs++; $display("FAIL async reset got v=%0b cnt=%0d cnt2=%0d want 0 0 0", out_valid, illegal_cnt, illegal_cnt2); end
    m_d = '0; m_valid = 0; m_cnt = 0; m_cnt2 = 0; in_valid = 0;
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 15) == 0;
      instr = gen(); pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      #1;
      n++; if (in_ready !== (!m_valid || out_ready)) begin errs++; $display("FAIL rnd in_ready got %0b want %0b", in_ready, !m_valid || out_ready); end
      n++; if ({out_valid, illegal, op_a, op_b, alu_op, rd, reg_write} !== {m_valid, m_d.ill, m_d.a, m_d.b, m_d.op, m_d.rd, m_d.we}) begin
        errs++; $display("FAIL rnd outputs got v=%0b ill=%0b a=%h b=%h op=%0d rd=%0d we=%0b want %0b %0b %h %h %0d %0d %0b",
          out_valid, illegal, op_a, op_b, alu_op, rd, reg_write, m_valid, m_d.ill, m_d.a, m_d.b, m_d.op, m_d.rd, m_d.we); end
      n++; if ({illegal_cnt, illegal_cnt2} !== {16'(m_cnt), 2'(m_cnt2)}) begin
        errs++; $display("FAIL rnd counts got %0d %0d want %0d %0d", illegal_cnt, illegal_cnt2, m_cnt, m_cnt2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_srai_lui();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/id_alu_issue.md
Name: id_alu_issue

Overview:
- Registered decode/issue stage that drives the 32-bit ALU: accepts a fetched RV32I instruction with its PC and register-file read data, and produces ALU operands A/B, the 4-bit ALU operation code, and writeback control.
- Sits between fetch/register-file read and execute, and is the producer side of the ALU operand/opcode interface.
- Uses a single-entry valid/ready pipeline register with flush support and a saturating illegal-instruction counter.

Parameters:
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- instr  in  32  RV32I instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file read, rs1.
- rs2_data  in  32  register-file read, rs2.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  issue register holds a valid op.
- out_ready  in  1  execute stage accepts.
- op_a  out  32  ALU operand A.
- op_b  out  32  ALU operand B.
- alu_op  out  4  ALU operation code.
- rd  out  5  destination register.
- reg_write  out  1  write rd at writeback.
- illegal  out  1  decoded op is illegal.
- illegal_cnt  out  CNT_W  saturating count of illegal ops accepted.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, op_a=0, op_b=0, alu_op=0, rd=0, reg_write=0, illegal=0, illegal_cnt=0.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on flush.
- Accept = in_valid && in_ready && !flush. On accept, all decoded outputs load on the next rising edge and out_valid=1. Latency is 1 cycle.
- If out_valid && out_ready && no accept: out_valid=0 and the data outputs hold their values.
- If out_valid && !out_ready: all outputs hold, in_ready=0 and the upstream stalls.
- flush=1: out_valid=0 next cycle and the incoming instruction is dropped. flush overrides accept.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- funct3 mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- Decode by opcode instr[6:0]:
  - 0110011 (OP): A=rs1_data, B=rs2_data. funct7=0100000 selects SUB (funct3 000) or SRA (funct3 101). funct7=0100000 with any other funct3 is illegal, as is any funct7 other than 0000000/0100000.
  - 0010011 (OP-IMM): A=rs1_data, B=sign-extended I-immediate. No SUBI; funct3 000 is always ADD.
    - Shifts: B[4:0]=instr[24:20] and B[31:5]=0.
    - SLLI requires instr[31:25]=0.
    - funct3 101 requires instr[31:25] of 0 (SRL) or 0100000 (SRA).
    - Any other upper-bit value on a shift is illegal.
  - 0110111 (LUI): A=0, B={instr[31:12],12'b0}, ADD.
  - 0010111 (AUIPC): A=pc, B={instr[31:12],12'b0}, ADD.
  - 0000011 (LOAD): A=rs1_data, B=sign-extended I-immediate, ADD, reg_write per the rd rule.
  - 0100011 (STORE): A=rs1_data, B=sign-extended S-immediate {instr[31:25],instr[11:7]}, ADD, reg_write=0, rd=0.
  - Any other opcode is illegal.
- Illegal op: alu_op=ADD, op_a=0, op_b=0, rd=0, reg_write=0, illegal=1. The op is still issued with out_valid=1.
- reg_write=1 only for legal OP/OP-IMM/LUI/AUIPC/LOAD with rd!=0. rd=instr[11:7] in those cases.
- illegal_cnt increments by 1 on each accepted illegal instruction and saturates at all-ones. Flushed instructions are not counted.
- All arithmetic is 32-bit. Immediates are sign-extended from instr[31]. No overflow flags.

Test Plan:
- Reset mid-operation: with out_valid=1, pulse rst_n=0 -> out_valid=0 and illegal_cnt=0 immediately, with no clock edge required.
- ADD/SUB: instr=0x002081B3, rs1_data=5, rs2_data=3, out_ready=1 -> next cycle out_valid=1, op_a=5, op_b=3, alu_op=0, rd=3, reg_write=1. Then instr=0x402081B3 -> alu_op=1.
- SRAI/LUI: instr=0x40335293, rs1_data=0x80000000 -> alu_op=7, op_b=3, rd=5. Then instr=0x123450B7 -> op_a=0, op_b=0x12345000, alu_op=0, rd=1.
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 with a new instruction -> in_ready=0 and outputs unchanged. Set out_ready=1 -> the new op appears the next cycle.
- Flush priority: in_valid=1, flush=1 while out_valid=1 -> next cycle out_valid=0, and the dropped instruction is never issued or counted.
- Illegal/saturation: instr=0x00000000 accepted -> illegal=1, reg_write=0, illegal_cnt=1. Using CNT_W=2 and 5 illegal ops -> illegal_cnt stays at 3.
